// File: rtl/conv_frame_loader.sv
// Byte-stream loader and run sequencer for the 2x2-output 3x3 convolution engine.
// Optional build macro CONV_FRAME_LOADER_KEEP_FILTER_EN adds s_last so a frame may end after the 16 input bytes.
module conv_frame_loader #(
  parameter int RUN_CYCLES = 66
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
  input  logic         s_last,
`endif
  input  logic         abort,
  input  logic         done_ack,
  output logic [127:0] i_flat,
  output logic [71:0]  f_flat,
  output logic         eng_rst,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] RC_LAST = 8'(RUN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  rc_q, rc_d;
  logic        eng_rst_q, busy_q, done_q;
  logic        xfer;
  logic        frame_end;
  logic [7:0]  i_mem_q [16];
  logic [7:0]  f_mem_q [9];

  assign xfer = (state_q == LOAD) && s_valid && !abort;

`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
  assign frame_end = (idx_q == 5'd24) || ((idx_q == 5'd15) && s_last);
`else
  assign frame_end = (idx_q == 5'd24);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rc_d    = rc_q;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          if (frame_end) begin
            idx_d   = 5'd0;
            state_d = KICK;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      KICK: begin
        rc_d    = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        rc_d = rc_q + 8'd1;
        if (rc_q == RC_LAST) state_d = DONE;
      end
      DONE: begin
        if (done_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    // Restart wins over any transfer or acknowledge in the same cycle.
    if (abort) begin
      state_d = LOAD;
      idx_d   = 5'd0;
      rc_d    = 8'd0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      idx_q     <= 5'd0;
      rc_q      <= 8'd0;
      eng_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rc_q      <= rc_d;
      // Decoded from the next state so the outputs come straight from flops.
      eng_rst_q <= (state_d == LOAD) || (state_d == KICK);
      busy_q    <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_imem
      always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
          i_mem_q[gi] <= 8'd0;
        end else if (xfer && (idx_q == 5'(gi))) begin
          i_mem_q[gi] <= s_data;
        end
      end
      assign i_flat[gi*8 +: 8] = i_mem_q[gi];
    end
    for (gi = 0; gi < 9; gi++) begin : g_fmem
      always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
          f_mem_q[gi] <= 8'd0;
        end else if (xfer && (idx_q == 5'(gi + 16))) begin
          f_mem_q[gi] <= s_data;
        end
      end
      assign f_flat[gi*8 +: 8] = f_mem_q[gi];
    end
  endgenerate

  assign s_ready = (state_q == LOAD);
  assign eng_rst = eng_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader: randomized frames against a byte-array reference model.
module tb_conv_frame_loader;

  localparam int RUN_CYCLES = 66;

  logic         clk_in;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic         abort;
  logic         done_ack;
  logic [127:0] i_flat;
  logic [71:0]  f_flat;
  logic         eng_rst;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;

  // Reference model: the matrices as byte arrays plus the next byte position.
  logic [7:0] exp_i [16];
  logic [7:0] exp_f [9];
  int         model_idx;

  conv_frame_loader #(.RUN_CYCLES(RUN_CYCLES)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
    .s_last   (s_last),
`endif
    .abort    (abort),
    .done_ack (done_ack),
    .i_flat   (i_flat),
    .f_flat   (f_flat),
    .eng_rst  (eng_rst),
    .busy     (busy),
    .done     (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] pack_i();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = exp_i[k];
    return v;
  endfunction

  function automatic logic [71:0] pack_f();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = exp_f[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) exp_i[k] = 8'd0;
    for (int k = 0; k < 9; k++) exp_f[k] = 8'd0;
    model_idx = 0;
  endtask

  // One accepted byte: first 16 go to the input matrix, the next 9 to the filter.
  task automatic model_xfer(input logic [7:0] d, input logic last, output bit ended);
    bit short_end;
`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
    short_end = (model_idx == 15) && last;
`else
    short_end = 1'b0;
`endif
    if (model_idx < 16) exp_i[model_idx] = d;
    else exp_f[model_idx - 16] = d;
    ended = (model_idx == 24) || short_end;
    model_idx = ended ? 0 : model_idx + 1;
  endtask

  // Streams n bytes with s_valid held high; byte k is base+k (or random when rnd).
  task automatic stream_bytes(input int n, input logic [7:0] base, input bit rnd);
    bit ended;
    s_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      s_data = rnd ? 8'($urandom) : 8'(base + 8'(k));
      @(posedge clk_in); #1;
      model_xfer(s_data, 1'b0, ended);
    end
    s_valid = 1'b0;
  endtask

  // Waits for done within a cycle budget, then acknowledges; ok=0 if it never came.
  task automatic wait_done_ack(output bit ok);
    int c;
    c = 0;
    while (!done && c < 300) begin
      @(posedge clk_in); #1;
      c++;
    end
    ok = done;
    done_ack = 1'b1;
    @(posedge clk_in); #1;
    done_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_checks++;
    if (i_flat !== 128'd0 || f_flat !== 72'd0 || eng_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: eng_rst=%b busy=%b done=%b i_flat=%h f_flat=%h, want 1 0 0 zeros",
               eng_rst, busy, done, i_flat, f_flat);
    end
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in); #1;
    n_checks++;
    if (s_ready !== 1'b1 || eng_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%b eng_rst=%b, want 1 1", s_ready, eng_rst);
    end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    int c;
    stream_bytes(25, 8'd1, 1'b0);
    n_checks++;
    if (s_ready !== 1'b0 || eng_rst !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_kick: s_ready=%b eng_rst=%b busy=%b, want 0 1 0", s_ready, eng_rst, busy);
    end
    n_checks++;
    if (i_flat !== pack_i() || f_flat !== pack_f()) begin
      n_fail++;
      $display("FAIL b2b_matrix: i_flat=%h f_flat=%h, want %h %h", i_flat, f_flat, pack_i(), pack_f());
    end
    n_checks++;
    if (i_flat[7:0] !== 8'd1 || i_flat[127:120] !== 8'd16 || f_flat[7:0] !== 8'd17 || f_flat[71:64] !== 8'd25) begin
      n_fail++;
      $display("FAIL b2b_corners: i00=%0d i33=%0d f00=%0d f22=%0d, want 1 16 17 25",
               i_flat[7:0], i_flat[127:120], f_flat[7:0], f_flat[71:64]);
    end
    @(posedge clk_in); #1;
    n_checks++;
    if (eng_rst !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: eng_rst=%b busy=%b, want 0 1", eng_rst, busy);
    end
    c = 0;
    while (!done && c < 300) begin
      @(posedge clk_in); #1;
      c++;
    end
    n_checks++;
    if (c !== RUN_CYCLES || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_run_len: cycles=%0d busy=%b done=%b, want %0d 0 1", c, busy, done, RUN_CYCLES);
    end
    $display("test_back_to_back done: run window %0d cycles", c);
  endtask

  task automatic test_done_hold();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in); #1;
      n_checks++;
      if (done !== 1'b1 || eng_rst !== 1'b0 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: done=%b eng_rst=%b s_ready=%b, want 1 0 0", k, done, eng_rst, s_ready);
      end
    end
    done_ack = 1'b1;
    @(posedge clk_in); #1;
    done_ack = 1'b0;
    n_checks++;
    if (s_ready !== 1'b1 || eng_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ack: s_ready=%b eng_rst=%b done=%b, want 1 1 0", s_ready, eng_rst, done);
    end
    $display("test_done_hold done");
  endtask

  task automatic test_valid_toggle();
    int  sent;
    int  cyc;
    bit  ended;
    bit  ok;
    sent = 0;
    cyc  = 0;
    while (sent < 25 && cyc < 200) begin
      n_checks++;
      if (s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL toggle_ready: byte %0d s_ready=%b, want 1", sent, s_ready);
      end
      s_valid = cyc[0];
      s_data  = 8'($urandom);
      @(posedge clk_in); #1;
      if (s_valid) begin
        model_xfer(s_data, 1'b0, ended);
        sent++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (s_ready !== 1'b0 || i_flat !== pack_i() || f_flat !== pack_f()) begin
      n_fail++;
      $display("FAIL toggle_matrix: s_ready=%b i_flat=%h f_flat=%h, want 0 %h %h",
               s_ready, i_flat, f_flat, pack_i(), pack_f());
    end
    wait_done_ack(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL toggle_done: done=0 after budget, want 1");
    end
    $display("test_valid_toggle done: %0d cycles for 25 bytes", cyc);
  endtask

  task automatic test_abort_load();
    stream_bytes(10, 8'd0, 1'b1);
    s_data  = 8'hEE;
    s_valid = 1'b1;
    abort   = 1'b1;
    @(posedge clk_in); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    model_idx = 0;
    n_checks++;
    if (s_ready !== 1'b1 || eng_rst !== 1'b1 || i_flat !== pack_i()) begin
      n_fail++;
      $display("FAIL abort_load: s_ready=%b eng_rst=%b i_flat=%h, want 1 1 %h", s_ready, eng_rst, i_flat, pack_i());
    end
    stream_bytes(25, 8'hA0, 1'b0);
    n_checks++;
    if (s_ready !== 1'b0 || i_flat !== pack_i() || f_flat !== pack_f() || f_flat[71:64] !== 8'hB8) begin
      n_fail++;
      $display("FAIL abort_reload: s_ready=%b i_flat=%h f_flat=%h, want 0 %h %h",
               s_ready, i_flat, f_flat, pack_i(), pack_f());
    end
    $display("test_abort_load done");
  endtask

  task automatic test_abort_run();
    int  wait_n;
    bit  seen;
    @(posedge clk_in); #1;
    wait_n = $urandom_range(5, 50);
    repeat (wait_n) @(posedge clk_in);
    #1;
    abort = 1'b1;
    @(posedge clk_in); #1;
    abort = 1'b0;
    n_checks++;
    if (eng_rst !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_run: eng_rst=%b busy=%b s_ready=%b done=%b, want 1 0 1 0", eng_rst, busy, s_ready, done);
    end
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_in); #1;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || i_flat !== pack_i() || f_flat !== pack_f()) begin
      n_fail++;
      $display("FAIL abort_run_after: done_seen=%b i_flat=%h f_flat=%h, want 0 %h %h",
               seen, i_flat, f_flat, pack_i(), pack_f());
    end
    $display("test_abort_run done: abort after %0d run cycles", wait_n);
  endtask

  task automatic test_async_reset();
    stream_bytes(25, 8'd0, 1'b1);
    repeat (1 + $urandom_range(3, 20)) @(posedge clk_in);
    #3;
    rst = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (i_flat !== pack_i() || f_flat !== pack_f() || eng_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: eng_rst=%b busy=%b done=%b i_flat=%h f_flat=%h, want 1 0 0 zeros",
               eng_rst, busy, done, i_flat, f_flat);
    end
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in); #1;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_release: s_ready=%b, want 1", s_ready);
    end
    $display("test_async_reset done");
  endtask

`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
  task automatic test_keep_filter();
    bit ended;
    bit ok;
    stream_bytes(16, 8'd0, 1'b1);
    stream_bytes(9, 8'h11, 1'b0);
    n_checks++;
    if (f_flat !== 72'h19_18_17_16_15_14_13_12_11) begin
      n_fail++;
      $display("FAIL keep_full_filter: f_flat=%h, want 191817161514131211", f_flat);
    end
    wait_done_ack(ok);
    s_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_data = 8'($urandom);
      s_last = (k == 5 || k == 15);
      @(posedge clk_in); #1;
      model_xfer(s_data, s_last, ended);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (s_ready !== 1'b0 || eng_rst !== 1'b1 || i_flat !== pack_i() || f_flat !== 72'h19_18_17_16_15_14_13_12_11) begin
      n_fail++;
      $display("FAIL keep_short_frame: s_ready=%b eng_rst=%b i_flat=%h f_flat=%h, want 0 1 %h 191817161514131211",
               s_ready, eng_rst, i_flat, f_flat, pack_i());
    end
    wait_done_ack(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL keep_done: done=0 after budget, want 1");
    end
    $display("test_keep_filter done");
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    s_data   = 8'd0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    abort    = 1'b0;
    done_ack = 1'b0;
    model_clear();
    test_reset();
    test_back_to_back();
    test_done_hold();
    test_valid_toggle();
    test_abort_load();
    test_abort_run();
    test_async_reset();
`ifdef CONV_FRAME_LOADER_KEEP_FILTER_EN
    test_keep_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
